fft_output_serializer: RTL and testbench
========================================

Name: fft_output_serializer

Overview:
- Consumer of the FFT engine's parallel result frame: captures each N-point frame (fft_out[N-1:0], qualified by out_valid) into a ping-pong buffer.
- Streams the frame out one complex sample per cycle over a valid/ready interface to the downstream demapper/equalizer.
- Double buffering lets frame k+1 arrive while frame k is still draining.
- Frames that arrive with no free bank are dropped and counted.

Parameters:
- N, 64, FFT size (power of 2, >=4); must match the FFT engine.
- IDX_W, $clog2(N), width of the sample index.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  one-cycle frame strobe (FFT out_valid)
- in_data  in  complex_product_t [N-1:0]  parallel frame, index k = bin k
- in_ready  out  1  at least one bank free (informational; producer has no stall)
- out_data  out  complex_product_t  current sample
- out_index  out  IDX_W  bin index of out_data
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the beat
- out_sof  out  1  first beat of frame (rd_idx==0), qualified by out_valid
- out_eof  out  1  last beat of frame (rd_idx==N-1), qualified by out_valid
- overflow  out  1  one-cycle pulse when a frame is dropped
- drop_count  out  CNT_W  saturating count of dropped frames

Behaviour:
- Storage: bank[2][N] of complex_product_t; full[1:0] flags; wr_bank and rd_bank 1-bit pointers; rd_idx IDX_W counter.
- Reset (synchronous): full=0, wr_bank=rd_bank=0, rd_idx=0, drop_count=0.
  - Outputs after the reset edge: out_valid=0, overflow=0, in_ready=1, out_sof=out_eof=0, out_index=0.
  - Reset mid-frame discards all buffered data. Bank contents are not cleared.
- Capture, on an in_valid cycle:
  - If bank[wr_bank] is free, or is being released this cycle (see the simultaneous-event rule), write all N samples, set full[wr_bank], toggle wr_bank.
  - Otherwise drop the frame: overflow=1 for one cycle, drop_count+=1 (saturating at all-ones). Buffer state is unchanged.
- Drain:
  - out_valid = full[rd_bank] (registered state, no combinational path from in_valid).
  - out_data = bank[rd_bank][rd_idx]; out_index = rd_idx.
  - A beat is accepted when out_valid && out_ready; rd_idx then increments.
  - On acceptance at rd_idx==N-1: rd_idx wraps to 0, full[rd_bank] clears, rd_bank toggles.
- Latency: a frame captured at edge t gives out_valid=1 in the cycle after t, with the first beat available immediately. Best case is N beats in N cycles.
- Back-to-back frames: with both banks full and out_ready held high, the frame boundary has no bubble. Beat N-1 of bank A is followed directly by beat 0 of bank B.
- Backpressure: while out_valid && !out_ready, out_data, out_index, out_sof and out_eof hold stable.
- Simultaneous event: in_valid in the same cycle as acceptance of the last beat of a full bank, with both banks full.
  - The released bank equals wr_bank; capture succeeds into it and no drop occurs.
  - Next cycle: the other bank drains; the new frame is queued behind it.
- in_ready = ~full[wr_bank]; it is purely informational.
- Input width equals output width; no arithmetic or scaling is performed.

Optional Feature:
- Macro: FFT_SER_SHIFT_EN.
- Defined: fftshift read order, so DC is mid-frame.
  - Physical read address = rd_idx XOR (N/2), giving bin sequence N/2..N-1, 0..N/2-1.
  - out_index reports the physical bin.
  - out_sof and out_eof still mark beat positions 0 and N-1.
- Undefined: natural order; out_index == rd_idx.

Test Plan:
- Single frame, N=64, in_data[k] = (re=k, im=-k), out_ready=1:
  - out_valid rises 1 cycle after capture.
  - 64 consecutive beats with out_index 0..63 and data (k,-k).
  - out_sof on beat 0, out_eof on beat 63; out_valid=0 on the following cycle.
- Backpressure, same frame with out_ready toggling 1,0,0,1 repeating:
  - Each sample is delivered exactly once, in order.
  - Outputs hold stable on stalled cycles.
  - 64 accepted beats in total.
- Three frames F0/F1/F2 strobed 2 cycles apart, out_ready=0:
  - F2 dropped: overflow pulse, drop_count=1, in_ready=0.
  - Raising out_ready then yields F0 then F1: 128 beats, no gap at the boundary.
- Both banks full; in_valid coincides with acceptance of the F0 eof beat:
  - No overflow.
  - Stream is F1 (64 beats) then the new frame (64 beats).
- Reset asserted at beat 20 of a frame:
  - Next cycle: out_valid=0, drop_count=0, in_ready=1.
  - A subsequent frame streams from index 0.
- With FFT_SER_SHIFT_EN defined, in_data[k]=k:
  - Beat sequence 32..63 then 0..31; out_sof at value 32, out_eof at value 31.

Source files
------------

// File: rtl/fft_output_serializer.sv
// Ping-pong frame buffer: captures parallel N-point FFT frames and streams them
// one sample per beat over valid/ready. Optional macro FFT_SER_SHIFT_EN: fftshift order.
package fft_ser_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_product_t;

endpackage

module fft_output_serializer
    import fft_ser_pkg::*;
#(
    parameter int N     = 64,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  complex_product_t [N-1:0] in_data,
    output logic                     in_ready,
    output complex_product_t         out_data,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sof,
    output logic                     out_eof,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(N / 2);

    complex_product_t bank_q [2][N];

    logic [1:0]       full_q,    full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] rd_idx_q,  rd_idx_d;
    logic [CNT_W-1:0] drop_q,    drop_d;
    logic             ovf_q,     ovf_d;

    logic             accept;
    logic             last_beat;
    logic             rel;
    logic             wr_free;
    logic             capture;
    logic             drop;
    logic [IDX_W-1:0] rd_addr;

    // A bank being released on the same edge counts as free for capture.
    assign accept    = full_q[rd_bank_q] & out_ready;
    assign last_beat = (rd_idx_q == LAST_IDX);
    assign rel       = accept & last_beat;
    assign wr_free   = ~full_q[wr_bank_q]
                     | (rel & (rd_bank_q == wr_bank_q));
    assign capture   = in_valid & wr_free;
    assign drop      = in_valid & ~wr_free;

`ifdef FFT_SER_SHIFT_EN
    // fftshift: upper half of the spectrum first, DC lands mid-frame.
    assign rd_addr = rd_idx_q ^ HALF_IDX;
`else
    assign rd_addr = rd_idx_q;
`endif

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state: release clears first so a same-cycle capture re-fills the bank.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        drop_d    = drop_q;
        ovf_d     = drop;
        if (accept) begin
            rd_idx_d = last_beat ? '0 : rd_idx_q + IDX_W'(1);
        end
        if (rel) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (capture) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (drop && !(&drop_q)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    // Frame storage: whole frame written in one cycle, never cleared.
    always_ff @(posedge clk) begin
        if (capture && !reset) begin
            for (int k = 0; k < N; k++) begin
                bank_q[wr_bank_q][k] <= in_data[k];
            end
        end
    end

    // Outputs come straight from registered state.
    always_comb begin
        out_valid  = full_q[rd_bank_q];
        out_data   = bank_q[rd_bank_q][rd_addr];
        out_index  = rd_addr;
        out_sof    = full_q[rd_bank_q] & (rd_idx_q == '0);
        out_eof    = full_q[rd_bank_q] & last_beat;
        in_ready   = ~full_q[wr_bank_q];
        overflow   = ovf_q;
        drop_count = drop_q;
    end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Scoreboard bench for fft_output_serializer: directed frames, expected beats
// queued at issue time, checked by a monitor on the falling edge.
module tb_fft_output_serializer;
    import fft_ser_pkg::*;

    localparam int N = 64;
    localparam int CNT_W = 16;
`ifdef FFT_SER_SHIFT_EN
    localparam bit SHIFT = 1'b1;
`else
    localparam bit SHIFT = 1'b0;
`endif

    typedef struct {
        complex_product_t d;
        logic [5:0]       idx;
        logic             sof;
        logic             eof;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    complex_product_t [N-1:0] in_data;
    logic                     in_ready;
    complex_product_t         out_data;
    logic [5:0]               out_index;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_sof;
    logic                     out_eof;
    logic                     overflow;
    logic [CNT_W-1:0]         drop_count;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   beats  = 0;
    bit   stall_v = 1'b0;
    logic [39:0] held;
    bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    fft_output_serializer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_bin(input int b);
        return SHIFT ? (b + N / 2) % N : b;
    endfunction

    task automatic push_frame(input int f);
        exp_t e;
        for (int b = 0; b < N; b++) begin
            int v;
            v = exp_bin(b) + 100 * f;
            e.d.re = 16'(v);
            e.d.im = 16'(-v);
            e.idx  = 6'(exp_bin(b));
            e.sof  = (b == 0);
            e.eof  = (b == N - 1);
            q.push_back(e);
        end
    endtask

    task automatic set_frame(input int f);
        for (int k = 0; k < N; k++) begin
            in_data[k].re = 16'(k + 100 * f);
            in_data[k].im = 16'(-(k + 100 * f));
        end
    endtask

    // Strobe a frame; returns at capture edge + 1.
    task automatic send_frame(input int f);
        set_frame(f);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit bp, input int exp_cyc, input string nm);
        int cyc;
        cyc = 0;
        while (q.size() != 0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bp) out_ready = pat[cyc % 4];
        end
        chk({nm, " drained"}, 64'(q.size()), 64'd0);
        if (exp_cyc > 0) chk({nm, " cycles"}, 64'(cyc), 64'(exp_cyc));
    endtask

    // Monitor: compare accepted beats and hold-stability on stalls.
    always @(negedge clk) begin
        if (!reset && stall_v) begin
            chk("stall hold",
                64'({out_data, out_index, out_sof, out_eof}), 64'(held));
        end
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected beat", 64'(out_index), 64'hFFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("beat data", 64'(out_data), 64'(e.d));
                chk("beat index", 64'(out_index), 64'(e.idx));
                chk("beat sof", 64'(out_sof), 64'(e.sof));
                chk("beat eof", 64'(out_eof), 64'(e.eof));
                beats++;
            end
        end
        stall_v = !reset && out_valid && !out_ready;
        held    = {out_data, out_index, out_sof, out_eof};
    end

    initial begin
        int b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst overflow", 64'(overflow), 64'd0);
        chk("rst drop_count", 64'(drop_count), 64'd0);
        chk("rst sof", 64'(out_sof), 64'd0);
        chk("rst eof", 64'(out_eof), 64'd0);
        chk("rst index", 64'(out_index), SHIFT ? 64'd32 : 64'd0);

        // Single frame, full throughput.
        out_ready = 1'b1;
        push_frame(0);
        send_frame(0);
        chk("t1 latency valid", 64'(out_valid), 64'd1);
        chk("t1 latency sof", 64'(out_sof), 64'd1);
        drain(1'b0, 64, "t1");
        chk("t1 idle after", 64'(out_valid), 64'd0);

        // Backpressure pattern 1,0,0,1.
        b0 = beats;
        push_frame(1);
        send_frame(1);
        drain(1'b1, 0, "t2");
        chk("t2 beats", 64'(beats - b0), 64'd64);
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Three frames, third has no free bank.
        push_frame(2);
        push_frame(3);
        send_frame(2);
        @(posedge clk);
        #1;
        send_frame(3);
        @(posedge clk);
        #1;
        send_frame(4);
        chk("t3 overflow", 64'(overflow), 64'd1);
        chk("t3 drop_count", 64'(drop_count), 64'd1);
        chk("t3 in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("t3 overflow pulse", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        drain(1'b0, 128, "t3");
        chk("t3 idle after", 64'(out_valid), 64'd0);

        // Capture coinciding with eof acceptance of the first bank.
        out_ready = 1'b0;
        push_frame(3);
        push_frame(4);
        send_frame(3);
        send_frame(4);
        chk("t4 both full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        repeat (63) @(posedge clk);
        #1;
        chk("t4 at eof", 64'(out_eof), 64'd1);
        push_frame(5);
        send_frame(5);
        chk("t4 no overflow", 64'(overflow), 64'd0);
        chk("t4 drop_count", 64'(drop_count), 64'd1);
        chk("t4 in_ready", 64'(in_ready), 64'd0);
        drain(1'b0, 128, "t4");

        // Reset in the middle of a frame.
        push_frame(6);
        send_frame(6);
        repeat (20) @(posedge clk);
        #1;
        chk("t5 mid index", 64'(out_index), 64'(exp_bin(20)));
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5 out_valid", 64'(out_valid), 64'd0);
        chk("t5 drop_count", 64'(drop_count), 64'd0);
        chk("t5 in_ready", 64'(in_ready), 64'd1);
        push_frame(7);
        send_frame(7);
        drain(1'b0, 64, "t5");

        repeat (2) @(posedge clk);
        #1;
        chk("final queue", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
